// File: rtl/sram_host_arbiter.sv
// Burst host bridge from a UART byte stream to a single-port SRAM.
// The SoC memory port shares the SRAM; the host wins in IDLE.
module sram_host_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int LEN_W  = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [7:0]             rx_data_out,
  input  logic                   rx_valid,
  output logic                   rx_ready,
  output logic                   rx_enable,
  input  logic                   tx_ready,
  output logic                   tx_valid,
  output logic [7:0]             tx_data_in,
  output logic                   tx_enable,
  output logic                   csb_n,
  output logic                   we_n,
  output logic [ADDR_W-1:0]      addr,
  output logic [DATA_W-1:0]      sram_data_in,
  output logic [DATA_W/8-1:0]    wmask,
  input  logic [DATA_W-1:0]      sram_data_out,
  output logic                   i_rst,
  input  logic                   sram_cs,
  input  logic                   sram_we,
  input  logic [ADDR_W-1:0]      sram_addr_serv,
  input  logic [DATA_W-1:0]      sram_data_write_serv,
  input  logic [DATA_W/8-1:0]    sram_wmask,
  output logic [DATA_W-1:0]      sram_data_read_serv,
  output logic                   sram_ack,
  output logic                   busy
);

  localparam int BYTES = DATA_W / 8;
  localparam int BI_W  = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [BI_W-1:0]  LAST = BI_W'(BYTES - 1);
  localparam logic [LEN_W:0]   ONE  = (LEN_W+1)'(1);

  typedef enum logic [2:0] {
    IDLE, ADDR, WDATA, WRITE,
    RD_REQ, RD_CAP, RD_SEND, SOC_ACK
  } state_t;

  state_t              state_q, state_d;
  logic                soc_run_q, soc_run_d;
  logic                rd_q, rd_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [LEN_W:0]      cnt_q, cnt_d;
  logic [ADDR_W-1:0]   a_ptr_q, a_ptr_d;
  logic [BI_W-1:0]     bidx_q, bidx_d;
  logic [DATA_W-1:0]   word_q, word_d;

  assign rx_enable = 1'b1;
  assign i_rst     = ~soc_run_q;
  assign busy      = (state_q != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      soc_run_q <= 1'b0;
      rd_q      <= 1'b0;
      len_q     <= '0;
      cnt_q     <= '0;
      a_ptr_q   <= '0;
      bidx_q    <= '0;
      word_q    <= '0;
    end else begin
      state_q   <= state_d;
      soc_run_q <= soc_run_d;
      rd_q      <= rd_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      a_ptr_q   <= a_ptr_d;
      bidx_q    <= bidx_d;
      word_q    <= word_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    soc_run_d = soc_run_q;
    rd_d      = rd_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    a_ptr_d   = a_ptr_q;
    bidx_d    = bidx_q;
    word_d    = word_q;
    rx_ready            = 1'b0;
    tx_valid            = 1'b0;
    tx_data_in          = '0;
    tx_enable           = 1'b0;
    csb_n               = 1'b1;
    we_n                = 1'b1;
    addr                = a_ptr_q;
    sram_data_in        = '0;
    wmask               = '0;
    sram_data_read_serv = '0;
    sram_ack            = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (rx_valid) begin
          rx_ready = 1'b1;
          unique case (rx_data_out[7:6])
            2'b00, 2'b01: begin
              rd_d    = rx_data_out[6];
              len_d   = rx_data_out[LEN_W-1:0];
              state_d = ADDR;
            end
            2'b10: soc_run_d = 1'b1;
            2'b11: soc_run_d = 1'b0;
          endcase
        end else if (soc_run_q && sram_cs) begin
          csb_n = 1'b0;
          addr  = sram_addr_serv;
          if (sram_we) begin
            we_n         = 1'b0;
            wmask        = sram_wmask;
            sram_data_in = sram_data_write_serv;
            sram_ack     = 1'b1;
          end else begin
            state_d = SOC_ACK;
          end
        end
      end
      ADDR: begin
        if (rx_valid) begin
          rx_ready = 1'b1;
          a_ptr_d  = rx_data_out[ADDR_W-1:0];
          cnt_d    = {1'b0, len_q} + ONE;
          bidx_d   = '0;
          state_d  = rd_q ? RD_REQ : WDATA;
        end
      end
      WDATA: begin
        if (rx_valid) begin
          rx_ready = 1'b1;
          // bytes arrive LSB first, so shift in from the top
          word_d = (word_q >> 8)
                 | (DATA_W'(rx_data_out) << (DATA_W - 8));
          if (bidx_q == LAST) begin
            bidx_d  = '0;
            state_d = WRITE;
          end else begin
            bidx_d = bidx_q + 1'b1;
          end
        end
      end
      WRITE: begin
        csb_n        = 1'b0;
        we_n         = 1'b0;
        wmask        = '1;
        sram_data_in = word_q;
        a_ptr_d      = a_ptr_q + 1'b1;
        cnt_d        = cnt_q - ONE;
        state_d      = (cnt_q == ONE) ? IDLE : WDATA;
      end
      RD_REQ: begin
        csb_n     = 1'b0;
        tx_enable = 1'b1;
        state_d   = RD_CAP;
      end
      RD_CAP: begin
        tx_enable = 1'b1;
        word_d    = sram_data_out;
        bidx_d    = '0;
        state_d   = RD_SEND;
      end
      RD_SEND: begin
        tx_enable = 1'b1;
        if (tx_ready) begin
          tx_valid   = 1'b1;
          tx_data_in = word_q[7:0];
          word_d     = word_q >> 8;
          if (bidx_q == LAST) begin
            bidx_d  = '0;
            a_ptr_d = a_ptr_q + 1'b1;
            cnt_d   = cnt_q - ONE;
            state_d = (cnt_q == ONE) ? IDLE : RD_REQ;
          end else begin
            bidx_d = bidx_q + 1'b1;
          end
        end
      end
      SOC_ACK: begin
        sram_ack            = 1'b1;
        sram_data_read_serv = sram_data_out;
        state_d             = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_sram_host_arbiter.sv
// Scoreboard bench for sram_host_arbiter with a behavioural SRAM.
// Expected writes, tx bytes and SoC acks are queued and checked by a monitor.
module tb_sram_host_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_data_out = '0;
  logic        rx_valid = 1'b0;
  logic        rx_ready, rx_enable;
  logic        tx_ready = 1'b1;
  logic        tx_valid;
  logic [7:0]  tx_data_in;
  logic        tx_enable;
  logic        csb_n, we_n;
  logic [4:0]  addr;
  logic [31:0] sram_data_in;
  logic [3:0]  wmask;
  logic [31:0] sram_data_out = '0;
  logic        i_rst;
  logic        sram_cs = 1'b0;
  logic        sram_we = 1'b0;
  logic [4:0]  sram_addr_serv = '0;
  logic [31:0] sram_data_write_serv = '0;
  logic [3:0]  sram_wmask = '0;
  logic [31:0] sram_data_read_serv;
  logic        sram_ack, busy;

  int total = 0;
  int bad = 0;
  logic throttle = 1'b0;

  logic [63:0] wr_q[$];
  logic [7:0]  tx_q[$];
  logic [31:0] ack_q[$];
  logic [31:0] mem [32];

  sram_host_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .rx_data_out(rx_data_out), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .rx_enable(rx_enable),
    .tx_ready(tx_ready), .tx_valid(tx_valid),
    .tx_data_in(tx_data_in), .tx_enable(tx_enable),
    .csb_n(csb_n), .we_n(we_n), .addr(addr),
    .sram_data_in(sram_data_in), .wmask(wmask),
    .sram_data_out(sram_data_out), .i_rst(i_rst),
    .sram_cs(sram_cs), .sram_we(sram_we),
    .sram_addr_serv(sram_addr_serv),
    .sram_data_write_serv(sram_data_write_serv),
    .sram_wmask(sram_wmask),
    .sram_data_read_serv(sram_data_read_serv),
    .sram_ack(sram_ack), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic void chk(string n, logic [63:0] a, logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", n, a, e);
    end
  endfunction

  // behavioural SRAM: byte-masked write, one-cycle read latency
  always @(posedge clk) begin
    if (!csb_n) begin
      if (!we_n) begin
        for (int i = 0; i < 4; i++)
          if (wmask[i]) mem[addr][8*i +: 8] <= sram_data_in[8*i +: 8];
      end else begin
        sram_data_out <= mem[addr];
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (throttle) tx_ready = ~tx_ready;
    else tx_ready = 1'b1;
  end

  // monitor
  always @(negedge clk) begin
    if (rst_n) begin
      if (!csb_n && !we_n) begin
        if (wr_q.size() == 0) chk("unexpected_write", {addr, sram_data_in, wmask}, 0);
        else chk("sram_write", {23'd0, addr, sram_data_in, wmask}, wr_q.pop_front());
      end
      if (tx_valid) begin
        chk("tx_ready_at_valid", tx_ready, 1);
        if (tx_q.size() == 0) chk("unexpected_tx", tx_data_in, 8'hxx);
        else chk("tx_byte", tx_data_in, tx_q.pop_front());
      end
      if (sram_ack) begin
        if (ack_q.size() == 0) chk("unexpected_ack", sram_data_read_serv, 32'hx);
        else chk("soc_ack_data", sram_data_read_serv, ack_q.pop_front());
      end
    end
  end

  task automatic send(input logic [7:0] b);
    int k = 0;
    @(posedge clk); #1;
    rx_data_out = b;
    rx_valid = 1'b1;
    @(negedge clk);
    while (!rx_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (!rx_ready) chk("rx_timeout", b, 8'hxx);
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int k = 0;
    @(negedge clk);
    while ((busy || tx_q.size() != 0 || wr_q.size() != 0) && k < 500) begin
      @(negedge clk);
      k++;
    end
    chk("idle_timeout", k < 500, 1);
  endtask

  task automatic soc_req(input logic we, input logic [4:0] a,
                         input logic [31:0] d, input logic [3:0] m,
                         output int lat);
    @(posedge clk); #1;
    sram_cs = 1'b1;
    sram_we = we;
    sram_addr_serv = a;
    sram_data_write_serv = d;
    sram_wmask = m;
    lat = 0;
    @(negedge clk);
    while (!sram_ack && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    @(posedge clk); #1;
    sram_cs = 1'b0;
  endtask

  initial begin
    int lat;
    int k;
    for (int i = 0; i < 32; i++) mem[i] = '0;

    // 1. reset state and run/halt
    @(negedge clk);
    chk("rst_i_rst", i_rst, 1);
    chk("rst_csb_n", csb_n, 1);
    chk("rst_we_n", we_n, 1);
    chk("rst_busy", busy, 0);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_sram_ack", sram_ack, 0);
    chk("rst_wmask", wmask, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    send(8'h80);
    chk("run_i_rst", i_rst, 0);
    send(8'hC0);
    chk("halt_i_rst", i_rst, 1);

    // 2. host write of 2 words wrapping at addr 31
    wr_q.push_back({23'd0, 5'd31, 32'h12345678, 4'hF});
    wr_q.push_back({23'd0, 5'd0, 32'hDEADBEEF, 4'hF});
    send(8'h01); send(8'h1F);
    send(8'h78); send(8'h56); send(8'h34); send(8'h12);
    send(8'hEF); send(8'hBE); send(8'hAD); send(8'hDE);
    wait_idle();

    // 3. host read of 2 words with throttled tx_ready
    tx_q.push_back(8'h78); tx_q.push_back(8'h56);
    tx_q.push_back(8'h34); tx_q.push_back(8'h12);
    tx_q.push_back(8'hEF); tx_q.push_back(8'hBE);
    tx_q.push_back(8'hAD); tx_q.push_back(8'hDE);
    throttle = 1'b1;
    send(8'h41); send(8'h1F);
    wait_idle();
    throttle = 1'b0;

    // 4. SoC masked write then read
    send(8'h80);
    wr_q.push_back({23'd0, 5'd3, 32'hA5A5A5A5, 4'b0011});
    ack_q.push_back(32'h0);
    soc_req(1'b1, 5'd3, 32'hA5A5A5A5, 4'b0011, lat);
    chk("soc_wr_lat", lat, 0);
    ack_q.push_back(32'h0000A5A5);
    soc_req(1'b0, 5'd3, 32'h0, 4'h0, lat);
    chk("soc_rd_lat", lat, 1);

    // 5. host and SoC together: host wins
    tx_q.push_back(8'h78); tx_q.push_back(8'h56);
    tx_q.push_back(8'h34); tx_q.push_back(8'h12);
    @(posedge clk); #1;
    rx_data_out = 8'h40;
    rx_valid = 1'b1;
    sram_cs = 1'b1;
    sram_we = 1'b0;
    sram_addr_serv = 5'd3;
    @(negedge clk);
    chk("prio_rx_ready", rx_ready, 1);
    chk("prio_no_ack", sram_ack, 0);
    @(posedge clk); #1;
    rx_data_out = 8'h1F;
    @(negedge clk);
    chk("prio_addr_rx_ready", rx_ready, 1);
    ack_q.push_back(32'h0000A5A5);
    @(posedge clk); #1;
    rx_valid = 1'b0;
    k = 0;
    @(negedge clk);
    while (!sram_ack && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("prio_ack_seen", sram_ack, 1);
    chk("prio_tx_done_before_ack", tx_q.size(), 0);
    @(posedge clk); #1;
    sram_cs = 1'b0;
    wait_idle();

    // 6. reset mid-burst
    send(8'h00); send(8'h05);
    send(8'h11); send(8'h22);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_i_rst", i_rst, 1);
    chk("mid_rst_csb_n", csb_n, 1);
    chk("mid_rst_we_n", we_n, 1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_tx_valid", tx_valid, 0);
    chk("mid_rst_sram_ack", sram_ack, 0);
    chk("mid_rst_wmask", wmask, 0);
    chk("mid_rst_no_write", mem[5], 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    wr_q.push_back({23'd0, 5'd5, 32'h44332211, 4'hF});
    send(8'h00); send(8'h05);
    send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    wait_idle();
    tx_q.push_back(8'h11); tx_q.push_back(8'h22);
    tx_q.push_back(8'h33); tx_q.push_back(8'h44);
    send(8'h40); send(8'h05);
    wait_idle();

    repeat (3) @(negedge clk);
    chk("left_wr", wr_q.size(), 0);
    chk("left_tx", tx_q.size(), 0);
    chk("left_ack", ack_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
